// File: rtl/kernel_c_kc_vout_sink.sv
// Output sink for a stall-frozen kernel pipeline: tracks in-flight valid words,
// buffers results in a FWFT FIFO and raises stall whenever the FIFO is full.
module kernel_c_kc_vout_sink #(
  parameter int unsigned DATAW  = 32,
  parameter int unsigned LAT    = 1,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NITEMS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     stall,
  input  logic [DATAW-1:0]         k_data,
  output logic [DATAW-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (NITEMS > 1) ? $clog2(NITEMS) : 1;

  logic [LAT-1:0]   vld_sr;
  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [IW-1:0]    item_cnt;
  logic [AW:0]      count_next;
  logic             wr;
  logic             rd;

  assign m_valid = (count != '0);
  assign wr      = vld_sr[LAT-1] & ~stall;
  assign rd      = m_valid & m_ready;
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid & (item_cnt == IW'(NITEMS - 1));

  always_comb begin
    count_next = count;
    if (wr && !rd)
      count_next = count + (AW + 1)'(1);
    else if (!wr && rd)
      count_next = count - (AW + 1)'(1);
  end

  // The valid shadow freezes together with the kernel so a stalled result
  // is written exactly once, on the first unstalled cycle.
  generate
    if (LAT == 1) begin : g_sr1
      always_ff @(posedge clk) begin
        if (!rst)
          vld_sr <= '0;
        else if (!stall)
          vld_sr <= in_valid;
      end
    end else begin : g_srn
      always_ff @(posedge clk) begin
        if (!rst)
          vld_sr <= '0;
        else if (!stall)
          vld_sr <= {vld_sr[LAT-2:0], in_valid};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      item_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr   <= rd_ptr + AW'(1);
        item_cnt <= m_last ? '0 : item_cnt + IW'(1);
      end
      count <= count_next;
      stall <= (count_next == (AW + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= k_data;
  end

endmodule

// File: tb/tb_kernel_c_kc_vout_sink.sv
// Bench for kernel_c_kc_vout_sink: LAT=1 and LAT=3 instances fed by a multiplier
// kernel stand-in, checked against an accepted-operand queue and item counter.
module tb_kernel_c_kc_vout_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       iv, rdy, st, mv, ml;
  logic [1:0][31:0] a, b, kd, md;
  logic [1:0][3:0]  cnt;
  logic [31:0]      k0;
  logic [2:0][31:0] k3;

  kernel_c_kc_vout_sink #(.DATAW(32), .LAT(1), .DEPTH(8), .NITEMS(16)) u_lat1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .stall(st[0]), .k_data(kd[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(rdy[0]), .m_last(ml[0]), .count(cnt[0]));

  kernel_c_kc_vout_sink #(.DATAW(32), .LAT(3), .DEPTH(8), .NITEMS(16)) u_lat3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .stall(st[1]), .k_data(kd[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(rdy[1]), .m_last(ml[1]), .count(cnt[1]));

  // Kernel stand-ins: product pipelines frozen by their sink's stall
  always @(posedge clk) begin
    if (!st[0]) k0 <= a[0] * b[0];
    if (!st[1]) k3 <= {k3[1:0], a[1] * b[1]};
  end
  assign kd[0] = k0;
  assign kd[1] = k3[2];

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          npass = 0;
  int          ntotal = 0;
  int          pops[2];
  int          accs[2];
  int          lasts[2];
  logic        b_rand;
  logic [31:0] nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qfront(input int c);
    return (c == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int c, input logic [31:0] v);
    if (c == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic qpop(input int c);
    if (c == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  // Called at a negedge with this cycle's inputs set; returns at the next negedge.
  task automatic tick();
    logic [1:0] acc;
    acc = '0;
    for (int c = 0; c < 2; c++) begin
      if (!rst) begin
        if (c == 0) q0.delete();
        else q1.delete();
        pops[c] = 0;
        accs[c] = 0;
        lasts[c] = 0;
      end else begin
        if (iv[c] && !st[c]) begin
          qpush(c, a[c] * b[c]);
          accs[c]++;
          acc[c] = 1'b1;
        end
        if (mv[c]) begin
          chk($sformatf("m_last_ch%0d_pop%0d", c, pops[c]), 32'(ml[c]), 32'((pops[c] % 16) == 15));
          if (qsize(c) == 0)
            chk($sformatf("spurious_valid_ch%0d", c), 32'(mv[c]), 32'd0);
          else
            chk($sformatf("m_data_ch%0d_pop%0d", c, pops[c]), md[c], qfront(c));
          if (rdy[c]) begin
            if (ml[c]) lasts[c]++;
            if (qsize(c) != 0) qpop(c);
            pops[c]++;
          end
        end else begin
          chk($sformatf("m_last_idle_ch%0d", c), 32'(ml[c]), 32'd0);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        a[c] = a[c] + 32'd1;
        b[c] = b_rand ? $urandom : 32'd2;
      end
    end
  endtask

  task automatic drain(input int c);
    iv[c] = 1'b0;
    rdy[c] = 1'b1;
    for (int g = 0; g < 100 && (qsize(c) != 0 || mv[c]); g++) tick();
    chk($sformatf("drain_empty_ch%0d", c), 32'(qsize(c)), 32'd0);
    chk($sformatf("drain_count_ch%0d", c), 32'(cnt[c]), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    iv = '0;
    rdy = '0;
    a = '0;
    b = '0;
    b_rand = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pops[c] = 0;
      accs[c] = 0;
      lasts[c] = 0;
    end
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("reset_count_ch%0d", c), 32'(cnt[c]), 32'd0);
      chk($sformatf("reset_valid_ch%0d", c), 32'(mv[c]), 32'd0);
      chk($sformatf("reset_stall_ch%0d", c), 32'(st[c]), 32'd0);
      chk($sformatf("reset_last_ch%0d", c), 32'(ml[c]), 32'd0);
    end
    rst = 1'b1;

    // T1: 16 products i*2 streamed straight through
    a[0] = 32'd0;
    b[0] = 32'd2;
    iv[0] = 1'b1;
    rdy[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t1_stall_low", 32'(st[0]), 32'd0);
      tick();
    end
    iv[0] = 1'b0;
    drain(0);
    chk("t1_pops", 32'(pops[0]), 32'd16);
    chk("t1_last_count", 32'(lasts[0]), 32'd1);

    // T2: fill until stall, then release
    b_rand = 1'b1;
    b[0] = $urandom;
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (12) tick();
    chk("t2_count_full", 32'(cnt[0]), 32'd8);
    chk("t2_stall_high", 32'(st[0]), 32'd1);
    chk("t2_accepted", 32'(qsize(0)), 32'd9);
    rdy[0] = 1'b1;
    tick();
    chk("t2_stall_release", 32'(st[0]), 32'd0);
    chk("t2_count_after_pop", 32'(cnt[0]), 32'd7);
    repeat (6) tick();
    drain(0);

    // T4: simultaneous write and read at count 4
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (5) tick();
    iv[0] = 1'b0;
    rdy[0] = 1'b1;
    chk("t4_count_before", 32'(cnt[0]), 32'd4);
    nxt = q0[1];
    tick();
    chk("t4_count_same", 32'(cnt[0]), 32'd4);
    chk("t4_head_advanced", md[0], nxt);
    drain(0);

    // T3: LAT=3, pattern 1,0,1,1 hits a full FIFO mid-pipeline
    a[1] = 32'd100;
    b[1] = $urandom;
    rdy[1] = 1'b0;
    iv[1] = 1'b1;
    for (int g = 0; g < 50 && accs[1] < 7; g++) tick();
    iv[1] = 1'b0;
    repeat (4) tick();
    chk("t3_count_pre", 32'(cnt[1]), 32'd7);
    iv[1] = 1'b1; tick();
    iv[1] = 1'b0; tick();
    iv[1] = 1'b1; tick();
    tick();
    iv[1] = 1'b0;
    repeat (3) tick();
    chk("t3_stall_high", 32'(st[1]), 32'd1);
    chk("t3_count_full", 32'(cnt[1]), 32'd8);
    chk("t3_accepted", 32'(qsize(1)), 32'd10);
    drain(1);
    chk("t3_pops", 32'(pops[1]), 32'd10);

    // T5: reset while full and stalled, then a fresh stream
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (12) tick();
    chk("t5_stall_before_reset", 32'(st[0]), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    iv[0] = 1'b0;
    chk("t5_count_cleared", 32'(cnt[0]), 32'd0);
    chk("t5_valid_cleared", 32'(mv[0]), 32'd0);
    chk("t5_stall_cleared", 32'(st[0]), 32'd0);
    repeat (3) tick();
    chk("t5_no_inflight_write", 32'(cnt[0]), 32'd0);
    a[0] = 32'd0;
    rdy[0] = 1'b1;
    iv[0] = 1'b1;
    for (int g = 0; g < 200 && accs[0] < 16; g++) tick();
    iv[0] = 1'b0;
    drain(0);
    chk("t5_pops", 32'(pops[0]), 32'd16);
    chk("t5_last_count", 32'(lasts[0]), 32'd1);

    // T6: two back-to-back streams with random handshakes on LAT=3
    for (int g = 0; g < 2000 && accs[1] < 32; g++) begin
      iv[1] = ($urandom % 4) != 0;
      rdy[1] = $urandom % 2;
      tick();
    end
    chk("t6_accepted", 32'(accs[1]), 32'd32);
    drain(1);
    chk("t6_pops", 32'(pops[1]), 32'd32);
    chk("t6_last_count", 32'(lasts[1]), 32'd2);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
